// File: rtl/sort_pkg.sv
// Shared types and helpers for the sequential exchange sorter.
package sort_pkg;

    // Controller states: waiting for a vector, sorting it, presenting it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } sort_state_e;

    // Number of compare-swap pairs (i<j) visited for n elements.
    function automatic int unsigned pair_count(input int unsigned n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-swap: lo gets the smaller operand, hi the larger.
module cmp_swap #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    // Swap only on strict greater-than so equal values stay in place.
    always_comb begin
        if (a > b) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/sort_seq_ctrl.sv
// Sequential exchange sorter: one compare-swap of (A[i],A[j]) per cycle,
// visiting every pair i<j once, then holding the ascending result.
module sort_seq_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               busy
);

    localparam int unsigned    IW     = $clog2(N);
    localparam logic [IW-1:0]  I_LAST = IW'(N - 2);
    localparam logic [IW-1:0]  J_LAST = IW'(N - 1);

    sort_state_e      state;
    sort_state_e      state_nx;
    logic [WIDTH-1:0] a [N];
    logic [IW-1:0]    i;
    logic [IW-1:0]    j;
    logic [WIDTH-1:0] cs_lo;
    logic [WIDTH-1:0] cs_hi;
    logic             load;
    logic             step;
    logic             last_pair;

    assign last_pair = (i == I_LAST) && (j == J_LAST);

    cmp_swap #(.WIDTH(WIDTH)) u_cmp_swap (
        .a  (a[i]),
        .b  (a[j]),
        .lo (cs_lo),
        .hi (cs_hi)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and handshake/status outputs.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = SORT;
                end
            end
            SORT: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_pair) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Element array and pair indices; on the final pair the indices return
    // to (0,1) instead of advancing, so i+2 never exceeds N-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned k = 0; k < N; k++) begin
                a[k] <= '0;
            end
            i <= '0;
            j <= IW'(1);
        end else if (load) begin
            for (int unsigned k = 0; k < N; k++) begin
                a[k] <= in_data[k*WIDTH +: WIDTH];
            end
            i <= '0;
            j <= IW'(1);
        end else if (step) begin
            a[i] <= cs_lo;
            a[j] <= cs_hi;
            if (last_pair) begin
                i <= '0;
                j <= IW'(1);
            end else if (j == J_LAST) begin
                i <= i + IW'(1);
                j <= i + IW'(2);
            end else begin
                j <= j + IW'(1);
            end
        end
    end

    // Result is only driven while it is valid; zero otherwise.
    always_comb begin
        out_data = '0;
        if (state == DONE) begin
            for (int unsigned k = 0; k < N; k++) begin
                out_data[k*WIDTH +: WIDTH] = a[k];
            end
        end
    end

endmodule

// File: tb/tb_sort_seq_ctrl.sv
// Scoreboard bench for sort_seq_ctrl (WIDTH=4, N=8).
module tb_sort_seq_ctrl;
    import sort_pkg::*;

    localparam int W     = 4;
    localparam int NN    = 8;
    localparam int DW    = W * NN;
    localparam int PAIRS = int'(pair_count(NN));

    typedef struct {
        logic [DW-1:0] data;
        int            acc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          busy;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   n_acc = 0;
    bit   mon_en = 1'b0;
    bit   rnd_rdy = 1'b0;
    exp_t q[$];

    logic          exp_ir, exp_ov, exp_busy;
    logic [DW-1:0] exp_data;
    int            el;

    sort_seq_ctrl #(.WIDTH(W), .N(NN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [DW-1:0] ref_sort(input logic [DW-1:0] v);
        logic [W-1:0]  e [NN];
        logic [W-1:0]  t;
        logic [DW-1:0] r;
        for (int k = 0; k < NN; k++) e[k] = v[k*W +: W];
        for (int x = 1; x < NN; x++) begin
            for (int y = x; y > 0; y--) begin
                if (e[y-1] > e[y]) begin
                    t = e[y-1]; e[y-1] = e[y]; e[y] = t;
                end
            end
        end
        for (int k = 0; k < NN; k++) r[k*W +: W] = e[k];
        return r;
    endfunction

    // Monitor: expected status from scoreboard head and elapsed cycles.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            el       = cyc - q[0].acc;
            exp_ir   = 1'b0;
            exp_busy = (el < PAIRS);
            exp_ov   = (el >= PAIRS);
            exp_data = exp_ov ? q[0].data : '0;
        end else begin
            exp_ir   = 1'b1;
            exp_busy = 1'b0;
            exp_ov   = 1'b0;
            exp_data = '0;
        end
        if (mon_en) begin
            check("in_ready", in_ready, exp_ir);
            check("busy", busy, exp_busy);
            check("out_valid", out_valid, exp_ov);
            check("out_data", out_data, exp_data);
        end
        if (rst) begin
            q.delete();
            mon_en = 1'b1;
        end else if (mon_en) begin
            if (exp_ov && out_ready) void'(q.pop_front());
            if (exp_ir && in_valid) begin
                q.push_back('{ref_sort(in_data), cyc + 1});
                n_acc++;
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [DW-1:0] v);
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (in_ready && !rst) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                return;
            end
        end
        check("send_timeout", 1, 0);
        in_valid = 1'b0;
    endtask

    task automatic wait_ov();
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        check("ov_timeout", 1, 0);
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (q.size() == 0 && in_ready) return;
        end
        check("idle_timeout", 1, 0);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);

        // Reversed vector, consumer always ready.
        out_ready = 1'b1;
        send(32'h1234_5678);
        wait_ov();
        check("rev_data", out_data, 32'h8765_4321);
        wait_idle();

        // All elements equal.
        send(32'hAAAA_AAAA);
        wait_ov();
        check("eq_data", out_data, 32'hAAAA_AAAA);
        wait_idle();

        // Output stalled 10 cycles; monitor checks the held value each cycle.
        @(posedge clk); #1 out_ready = 1'b0;
        send(32'hF109_3F03);
        wait_ov();
        check("stall_data", out_data, 32'hFF93_3100);
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        check("stall_data_end", out_data, 32'hFF93_3100);
        @(negedge clk);
        check("stall_idle", in_ready, 1);

        // Reset on the 12th SORT edge discards the partial sort.
        send(32'h5A3C_96E1);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        send(32'h0000_0001);
        wait_ov();
        check("midrst_new", out_data, 32'h1000_0000);
        wait_idle();

        // in_valid held high with changing data through SORT and DONE.
        @(posedge clk); #1 out_ready = 1'b0;
        base     = n_acc;
        in_valid = 1'b1;
        in_data  = 32'h0F1E_2D3C;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            #1;
            if (n_acc >= base + 2) break;
            in_data = DW'($urandom);
            if (n == 35) out_ready = 1'b1;
        end
        check("hold_accepts", n_acc - base, 2);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Random vectors with random consumer stalls.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            send(DW'($urandom));
        end
        wait_idle();
        rnd_rdy = 1'b0;

        check("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sort_seq_ctrl.md
SORT_SEQ_CTRL -- requirements
Module: sort_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, element width in bits (unsigned).
REQ-002 SHALL have parameter N, default 8, element count; legal range 2..16.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_data holds a vector to sort.
REQ-007 in_ready  output  1  block accepts a vector this cycle.
REQ-008 in_data  input  N*WIDTH  element k at bits [k*WIDTH +: WIDTH].
REQ-009 out_valid  output  1  out_data holds the sorted vector.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 out_data  output  N*WIDTH  ascending order, element 0 smallest, same packing as in_data.
REQ-012 busy  output  1  high in SORT state.

Function
REQ-013 SHALL implement FSM states IDLE, SORT, DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, load in_data into internal array A[0..N-1], set i=0, j=1, go SORT.
REQ-015 SORT: exactly one compare-swap per cycle on pair (A[i],A[j]); swap iff A[i]>A[j] unsigned; equal values not swapped.
REQ-016 Index sequencing: j increments; when j=N-1, i increments and j=i+2; SORT ends after pair (N-2,N-1).
REQ-017 SORT SHALL last exactly N*(N-1)/2 cycles (28 for N=8); last compare-swap edge also moves FSM to DONE.
REQ-018 Latency: acceptance at edge T -> out_valid first high after edge T+N*(N-1)/2.
REQ-019 DONE: out_valid=1, out_data=A, held stable until out_valid&out_ready; then go IDLE next edge.
REQ-020 in_ready SHALL be 0 in SORT and DONE; in_valid there is ignored, in_data not sampled.
REQ-021 in_valid high in IDLE for consecutive cycles: each accepted handshake starts a new sort only after the previous output handshake.
REQ-022 out_ready high before DONE SHALL have no effect.
REQ-023 out_data SHALL be 0 whenever out_valid=0.
REQ-024 in_data changing during SORT SHALL not affect the result.

Reset
REQ-025 rst high at an edge SHALL force IDLE, A=0, i=0, j=1, from any state, including mid-SORT (partial result discarded).
REQ-026 Reset values visible after that edge: in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-027 rst has priority over in_valid and out_ready at the same edge.

Structure
REQ-028 State encoding enum and localparam pair-count function N*(N-1)/2 SHALL live in shared package sort_pkg.
REQ-029 Compare-swap SHALL be a sub-module cmp_swap (combinational, WIDTH-parameterized: inputs a,b; outputs lo,hi).
REQ-030 Index counters SHALL be $clog2(N) bits wide; no wrap beyond N-1.

Verification
REQ-031 Load {8,7,6,5,4,3,2,1} (element 0 = 8), out_ready=1 -> out_valid after 28 cycles, out_data elements {1..8}; in_ready low throughout.
REQ-032 Load all elements 4'hA -> out_data all 4'hA; no swap occurs (A unchanged every cycle).
REQ-033 Load {3,0,F,3,9,0,1,F}, out_ready=0 for 10 cycles after out_valid -> out_data stable {0,0,1,3,3,9,F,F}; IDLE one edge after out_ready=1.
REQ-034 Assert rst at cycle 12 of SORT -> next cycle in_ready=1, out_valid=0, busy=0; new vector {1,0,...} then sorts correctly.
REQ-035 Hold in_valid=1 with changing in_data during SORT and DONE -> only first vector sorted; second accepted one cycle after output handshake.
REQ-036 Random vectors, 1000 iterations, random out_ready stalls -> out_data matches reference ascending sort; latency exactly 28 cycles.
